instr_reg_arbiter: RTL

//  Shares the instruction register load port between NUM_REQ requesters.
//  - Round-robin grant among requesters.
//  - Write pointer allocated sequentially, wrapping at DEPTH.
//  - Tracks occupancy and hands out the read pointer, so the register file behaves as a circular queue.
//  - Sits between the test/stimulus sources and instr_register: drives load_en, write_pointer, opcode and operands.

---
 rtl/instr_reg_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/instr_reg_arbiter.sv
// instr_reg_arbiter
// Round-robin arbiter in front of the instruction register file. It grants one
// requester per cycle, registers the winning opcode/operands together with a
// sequential write pointer, and tracks the read side so the register file acts
// as a circular queue of DEPTH entries.
module instr_reg_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 5,
  parameter int OPC_W   = 4,
  parameter int OPD_W   = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*OPC_W-1:0]     req_opcode,
  input  logic [NUM_REQ*OPD_W-1:0]     req_operand_a,
  input  logic [NUM_REQ*OPD_W-1:0]     req_operand_b,
  input  logic                         pause,
  input  logic                         flush,
  input  logic                         rd_en,
  output logic                         load_en,
  output logic [ADDR_W-1:0]            write_pointer,
  output logic [OPC_W-1:0]             opcode,
  output logic signed [OPD_W-1:0]      operand_a,
  output logic signed [OPD_W-1:0]      operand_b,
  output logic [ADDR_W-1:0]            read_pointer,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic [ADDR_W:0]              count,
  output logic                         full,
  output logic                         empty
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  // Legacy-compatible state encoding.
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]        state, state_next;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_q, count_next;
  logic [ID_W-1:0]   last_grant, winner, scan_idx;
  logic              winner_found, grant_en, grant, pop, full_next;
  logic [OPC_W-1:0]  sel_opcode;
  logic [OPD_W-1:0]  sel_operand_a, sel_operand_b;

  assign full         = (count_q == DEPTH);
  assign empty        = (count_q == '0);
  assign count        = count_q;
  assign read_pointer = rd_ptr;

  // Granting only from RUN, never during flush/pause/full, and never while
  // reset is asserted so req_ready drops together with the registered outputs.
  assign grant_en = !reset && (state == ST_RUN) && !flush && !pause && !full;
  assign grant    = grant_en && winner_found;
  assign pop      = rd_en && !empty && !flush;

  // Round-robin search: first valid requester after last_grant, modulo NUM_REQ.
  // Scanning from the farthest offset down lets the nearest one overwrite.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise the combinational block would infer a latch.
    winner_found = 1'b0;
    winner       = '0;
    scan_idx     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan_idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[scan_idx]) begin
        winner_found = 1'b1;
        winner       = scan_idx;
      end
    end
  end

  // One-hot ready to the winner in the same cycle.
  always_comb begin
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  assign sel_opcode    = req_opcode[int'(winner)*OPC_W +: OPC_W];
  assign sel_operand_a = req_operand_a[int'(winner)*OPD_W +: OPD_W];
  assign sel_operand_b = req_operand_b[int'(winner)*OPD_W +: OPD_W];

  // Occupancy after this edge: grant and pop in the same cycle cancel out.
  always_comb begin
    count_next = count_q;
    if (flush)
      count_next = '0;
    else if (grant && !pop)
      count_next = count_q + (ADDR_W+1)'(1);
    else if (pop && !grant)
      count_next = count_q - (ADDR_W+1)'(1);
  end

  assign full_next = (count_next == DEPTH);

  // FSM next state. HOLD looks at next-cycle fullness so a pop in a full
  // cycle reopens granting on the very next cycle.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ST_FLUSH;
    end else begin
      case (state)
        ST_RUN:  if (pause || full_next)   state_next = ST_HOLD;
        ST_HOLD: if (!pause && !full_next) state_next = ST_RUN;
        default: state_next = ST_RUN;
      endcase
    end
  end

  // Control state: FSM, queue pointers, occupancy and round-robin memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RUN;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state   <= state_next;
      count_q <= count_next;
      if (grant) last_grant <= winner;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (grant) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (pop)   rd_ptr <= rd_ptr + ADDR_W'(1);
      end
    end
  end

  // Load stage: one cycle after a grant, present the write strobe, address and
  // the winner's fields; data outputs hold between loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_en       <= 1'b0;
      write_pointer <= '0;
      opcode        <= '0;
      operand_a     <= '0;
      operand_b     <= '0;
      grant_id      <= '0;
    end else begin
      load_en <= grant;
      if (grant) begin
        write_pointer <= wr_ptr;
        opcode        <= sel_opcode;
        operand_a     <= sel_operand_a;
        operand_b     <= sel_operand_b;
        grant_id      <= winner;
      end
    end
  end

endmodule
